// File: rtl/qinfen_apb3_slave_if_if.sv
// APB3 completer-side bus bundle for the example slave register bank front end.
interface qinfen_apb3_slave_if_if #(
    parameter int ADDRWIDTH = 12
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDRWIDTH-1:0] paddr;
    logic [31:0]          pwdata;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/qinfen_apb3_slave_if.sv
// APB3 front end: latches the setup phase, waits RD_WAIT/WR_WAIT cycles, fires a one-cycle
// register strobe and returns a registered response; illegal accesses get PSLVERR and no strobe.
module qinfen_apb3_slave_if #(
    parameter int ADDRWIDTH = 12,
    parameter int RD_WAIT   = 0,
    parameter int WR_WAIT   = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    qinfen_apb3_slave_if_if.slave apb,
    output logic [ADDRWIDTH-1:0]  addr,
    output logic                  read_en,
    output logic                  write_en,
    output logic [31:0]           wdata,
    input  logic [31:0]           rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, STROBE, RESP} state_t;

    localparam logic [ADDRWIDTH-1:0] LO_END  = ADDRWIDTH'(12'h00F);
    localparam logic [ADDRWIDTH-1:0] ID_BASE = ADDRWIDTH'(12'hFD0);

    state_t     state;
    logic       dir;
    logic       err;
    logic [3:0] cnt;
    logic       lo_space;
    logic       id_space;
    logic       setup_err;

    // ID space runs to the top of the 12-bit map, so only its lower bound needs checking
    always_comb begin
        lo_space  = (apb.paddr <= LO_END);
        id_space  = (apb.paddr >= ID_BASE);
        setup_err = (|apb.paddr[1:0]) | ~(lo_space | id_space) | (apb.pwrite & id_space);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            dir         <= 1'b0;
            err         <= 1'b0;
            cnt         <= 4'd0;
            addr        <= '0;
            wdata       <= '0;
            read_en     <= 1'b0;
            write_en    <= 1'b0;
            apb.prdata  <= '0;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
        end else begin
            read_en  <= 1'b0;
            write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        addr  <= apb.paddr;
                        wdata <= apb.pwdata;
                        dir   <= apb.pwrite;
                        err   <= setup_err;
                        cnt   <= apb.pwrite ? 4'(WR_WAIT) : 4'(RD_WAIT);
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!apb.psel) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (err) begin
                        apb.prdata  <= '0;
                        apb.pready  <= 1'b1;
                        apb.pslverr <= 1'b1;
                        state       <= RESP;
                    end else begin
                        // strobes are registered on entry so they are high for the whole STROBE cycle
                        read_en  <= ~dir;
                        write_en <= dir;
                        state    <= STROBE;
                    end
                end
                STROBE: begin
                    if (!apb.psel) begin
                        state <= IDLE;
                    end else begin
                        apb.prdata  <= dir ? 32'd0 : rdata;
                        apb.pready  <= 1'b1;
                        apb.pslverr <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    apb.pready  <= 1'b0;
                    apb.pslverr <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qinfen_apb3_slave_if.sv
// Directed bench: two front ends (no wait states / RD_WAIT=3,WR_WAIT=4) each backed by a small register model.
module tb_qinfen_apb3_slave_if;
    logic        pclk = 1'b0;
    logic        presetn;
    int          tests = 0;
    int          fails = 0;
    int          sel   = 0;
    int          ovl_err = 0;

    logic        m_psel, m_penable, m_pwrite;
    logic [11:0] m_paddr;
    logic [31:0] m_pwdata;

    always #5 pclk = ~pclk;

    qinfen_apb3_slave_if_if #(.ADDRWIDTH(12)) bus0 ();
    qinfen_apb3_slave_if_if #(.ADDRWIDTH(12)) bus1 ();

    assign bus0.psel    = m_psel    & (sel == 0);
    assign bus0.penable = m_penable & (sel == 0);
    assign bus0.pwrite  = m_pwrite;
    assign bus0.paddr   = m_paddr;
    assign bus0.pwdata  = m_pwdata;
    assign bus1.psel    = m_psel    & (sel == 1);
    assign bus1.penable = m_penable & (sel == 1);
    assign bus1.pwrite  = m_pwrite;
    assign bus1.paddr   = m_paddr;
    assign bus1.pwdata  = m_pwdata;

    logic        pready_m, pslverr_m;
    logic [31:0] prdata_m;
    assign pready_m  = (sel == 1) ? bus1.pready  : bus0.pready;
    assign pslverr_m = (sel == 1) ? bus1.pslverr : bus0.pslverr;
    assign prdata_m  = (sel == 1) ? bus1.prdata  : bus0.prdata;

    logic [11:0] addr0, addr1;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] wdata0, wdata1, rdata0, rdata1;

    qinfen_apb3_slave_if #(.ADDRWIDTH(12), .RD_WAIT(0), .WR_WAIT(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .apb(bus0), .addr(addr0),
        .read_en(rd0), .write_en(wr0), .wdata(wdata0), .rdata(rdata0));

    qinfen_apb3_slave_if #(.ADDRWIDTH(12), .RD_WAIT(3), .WR_WAIT(4)) dut1 (
        .pclk(pclk), .presetn(presetn), .apb(bus1), .addr(addr1),
        .read_en(rd1), .write_en(wr1), .wdata(wdata1), .rdata(rdata1));

    // register block model: data0..3 at 0x000-0x00C, read-only ID words above 0xFD0
    logic [31:0] regs0 [4];
    logic [31:0] regs1 [4];
    int          wrc [2];
    int          rdc [2];

    function automatic logic [31:0] id_val(input logic [11:0] a);
        case (a)
            12'hFE0: id_val = 32'h0000_0018;
            12'hFF4: id_val = 32'h0000_00F0;
            default: id_val = 32'h0;
        endcase
    endfunction

    assign rdata0 = (addr0 < 12'h010) ? regs0[addr0[3:2]] : id_val(addr0);
    assign rdata1 = (addr1 < 12'h010) ? regs1[addr1[3:2]] : id_val(addr1);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < 4; i++) begin
                regs0[i] <= '0;
                regs1[i] <= '0;
            end
        end else begin
            if (wr0 && addr0 < 12'h010) regs0[addr0[3:2]] <= wdata0;
            if (wr1 && addr1 < 12'h010) regs1[addr1[3:2]] <= wdata1;
        end
    end

    initial begin
        wrc[0] = 0; wrc[1] = 0; rdc[0] = 0; rdc[1] = 0;
    end

    always @(posedge pclk) begin
        if (wr0) wrc[0] <= wrc[0] + 1;
        if (rd0) rdc[0] <= rdc[0] + 1;
        if (wr1) wrc[1] <= wrc[1] + 1;
        if (rd1) rdc[1] <= rdc[1] + 1;
        if ((rd0 && wr0) || (rd1 && wr1)) ovl_err <= ovl_err + 1;
    end

    // one full transfer; leaves the bus idle only after the completing edge so calls chain back-to-back
    task automatic apb_xfer(input int s, input logic w, input logic [11:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic er, output int lat);
        sel = s; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = w; m_paddr = a; m_pwdata = d;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        lat = 1;
        while (pready_m !== 1'b1 && lat < 40) begin
            @(posedge pclk); #1;
            lat++;
        end
        tests++;
        if (pready_m !== 1'b1) begin
            $display("FAIL xfer_timeout addr=%h got pready=%b want 1", a, pready_m);
            fails++;
        end
        rd = prdata_m;
        er = pslverr_m;
        @(posedge pclk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({bus0.pready, bus0.pslverr, rd0, wr0} !== 4'b0 || bus0.prdata !== 32'h0 ||
            addr0 !== 12'h0 || wdata0 !== 32'h0) begin
            $display("FAIL reset_outputs got pready=%b pslverr=%b rd=%b wr=%b prdata=%h addr=%h wdata=%h want all 0",
                     bus0.pready, bus0.pslverr, rd0, wr0, bus0.prdata, addr0, wdata0);
            fails++;
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat; int w0, r0;
        w0 = wrc[0]; r0 = rdc[0];
        apb_xfer(0, 1'b1, 12'h004, 32'hA5A5_0001, rd, er, lat);
        tests++;
        if (lat !== 3 || er !== 1'b0 || wrc[0] - w0 !== 1 || rdc[0] !== r0) begin
            $display("FAIL basic_write got lat=%0d err=%b wr=%0d rd=%0d want 3 0 1 0",
                     lat, er, wrc[0] - w0, rdc[0] - r0);
            fails++;
        end
        tests++;
        if (addr0 !== 12'h004 || wdata0 !== 32'hA5A5_0001) begin
            $display("FAIL basic_hold got addr=%h wdata=%h want 004 a5a50001", addr0, wdata0);
            fails++;
        end
        w0 = wrc[0]; r0 = rdc[0];
        apb_xfer(0, 1'b0, 12'h004, 32'h0, rd, er, lat);
        tests++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hA5A5_0001 || rdc[0] - r0 !== 1 || wrc[0] !== w0) begin
            $display("FAIL basic_read got lat=%0d err=%b data=%h rd=%0d want 3 0 a5a50001 1",
                     lat, er, rd, rdc[0] - r0);
            fails++;
        end
    endtask

    task automatic test_wait_id();
        logic [31:0] rd; logic er; int lat;
        apb_xfer(1, 1'b0, 12'hFE0, 32'h0, rd, er, lat);
        tests++;
        if (lat !== 6 || er !== 1'b0 || rd !== 32'h18) begin
            $display("FAIL wait_id_fe0 got lat=%0d err=%b data=%h want 6 0 00000018", lat, er, rd);
            fails++;
        end
        apb_xfer(1, 1'b0, 12'hFF4, 32'h0, rd, er, lat);
        tests++;
        if (lat !== 6 || er !== 1'b0 || rd !== 32'hF0) begin
            $display("FAIL wait_id_ff4 got lat=%0d err=%b data=%h want 6 0 000000f0", lat, er, rd);
            fails++;
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; int w0, r0;
        logic [11:0] ea [3];
        logic        ew [3];
        ea[0] = 12'hFE0; ew[0] = 1'b1;
        ea[1] = 12'h100; ew[1] = 1'b0;
        ea[2] = 12'h006; ew[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w0 = wrc[0]; r0 = rdc[0];
            apb_xfer(0, ew[i], ea[i], 32'hFFFF_FFFF, rd, er, lat);
            tests++;
            if (er !== 1'b1 || rd !== 32'h0 || wrc[0] !== w0 || rdc[0] !== r0) begin
                $display("FAIL err_%h got err=%b data=%h strobes=%0d/%0d want 1 0 0/0",
                         ea[i], er, rd, wrc[0] - w0, rdc[0] - r0);
                fails++;
            end
        end
        tests++;
        if (regs0[1] !== 32'hA5A5_0001) begin
            $display("FAIL err_no_side_effect got data1=%h want a5a50001", regs0[1]);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        logic [11:0] ba [3];
        logic [31:0] bd [3];
        ba[0] = 12'h000; bd[0] = 32'h1111_1111;
        ba[1] = 12'h008; bd[1] = 32'h2222_2222;
        ba[2] = 12'h00C; bd[2] = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            apb_xfer(0, 1'b1, ba[i], bd[i], rd, er, lat);
            tests++;
            if (lat !== 3 || er !== 1'b0) begin
                $display("FAIL b2b_write_%0d got lat=%0d err=%b want 3 0", i, lat, er);
                fails++;
            end
        end
        tests++;
        if (regs0[0] !== 32'h1111_1111 || regs0[1] !== 32'hA5A5_0001 ||
            regs0[2] !== 32'h2222_2222 || regs0[3] !== 32'h3333_3333) begin
            $display("FAIL b2b_regs got %h %h %h %h want 11111111 a5a50001 22222222 33333333",
                     regs0[0], regs0[1], regs0[2], regs0[3]);
            fails++;
        end
        for (int i = 0; i < 3; i++) begin
            apb_xfer(0, 1'b0, ba[i], 32'h0, rd, er, lat);
            tests++;
            if (lat !== 3 || er !== 1'b0 || rd !== bd[i]) begin
                $display("FAIL b2b_read_%0d got lat=%0d err=%b data=%h want 3 0 %h", i, lat, er, rd, bd[i]);
                fails++;
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int lat; int w1; int rdy;
        w1 = wrc[1]; rdy = 0;
        sel = 1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 12'h008; m_pwdata = 32'hDEAD_BEEF;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge pclk); #1;
            if (bus1.pready === 1'b1) rdy++;
        end
        m_psel = 1'b0; m_penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pclk); #1;
            if (bus1.pready === 1'b1 || wr1 === 1'b1) rdy++;
        end
        tests++;
        if (rdy !== 0 || wrc[1] !== w1 || regs1[2] !== 32'h0) begin
            $display("FAIL abort got pready/strobe hits=%0d writes=%0d data2=%h want 0 0 00000000",
                     rdy, wrc[1] - w1, regs1[2]);
            fails++;
        end
        apb_xfer(1, 1'b0, 12'h008, 32'h0, rd, er, lat);
        tests++;
        if (lat !== 6 || er !== 1'b0 || rd !== 32'h0) begin
            $display("FAIL abort_recover got lat=%0d err=%b data=%h want 6 0 00000000", lat, er, rd);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int w0;
        sel = 0; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 12'h00C; m_pwdata = 32'h1234_5678;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        @(posedge pclk); #1;
        tests++;
        if (wr0 !== 1'b1) begin
            $display("FAIL rst_mid_strobe got write_en=%b want 1", wr0);
            fails++;
        end
        w0 = wrc[0];
        #2 presetn = 1'b0;
        #1;
        tests++;
        if (wr0 !== 1'b0 || rd0 !== 1'b0 || bus0.pready !== 1'b0 || bus0.pslverr !== 1'b0 ||
            bus0.prdata !== 32'h0 || addr0 !== 12'h0 || wdata0 !== 32'h0) begin
            $display("FAIL rst_mid_outputs got wr=%b rd=%b pready=%b prdata=%h addr=%h wdata=%h want all 0",
                     wr0, rd0, bus0.pready, bus0.prdata, addr0, wdata0);
            fails++;
        end
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge pclk); #3 presetn = 1'b1;
        @(posedge pclk); #1;
        apb_xfer(0, 1'b0, 12'h00C, 32'h0, rd, er, lat);
        tests++;
        if (wrc[0] !== w0 || lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
            $display("FAIL rst_mid_readback got writes=%0d lat=%0d err=%b data=%h want 0 3 0 00000000",
                     wrc[0] - w0, lat, er, rd);
            fails++;
        end
    endtask

    initial begin
        presetn = 1'b0;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
        #12;
        test_reset();
        #10 presetn = 1'b1;
        @(posedge pclk); #1;
        test_basic();
        test_wait_id();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        tests++;
        if (ovl_err !== 0) begin
            $display("FAIL strobe_overlap got %0d cycles want 0", ovl_err);
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
